trace_capture: RTL and testbench
================================

// Module: trace_capture
// PURPOSE
//  Synthesizable on-chip retire-trace buffer for the RISC-V core.
//  - Captures per-retire records {pc, inst, wb_addr, wb_data} into a DEPTH-entry buffer.
//  - Stops on exit, PC trigger or cycle timeout, then drains oldest-first as a valid/ready word stream.
//  - The stream feeds the UART path, so runs can be inspected in silicon without a simulator.
// PARAMETERS
//  XLEN        32     data/pc width; inst is fixed 32b, zero-extended if XLEN>32
//  DEPTH       16     entries; power of 2, >=2
//  MAX_CYCLES  13312  CAPTURE-cycle limit before timeout; 0 disables
// PORTS
//  clk          in   1                clock, all logic on posedge
//  rst          in   1                synchronous, active-high reset
//  arm          in   1                start capture (accepted in IDLE/DONE only)
//  mode         in   1                0=STOP (halt when full), 1=WRAP (keep last DEPTH)
//  trc_valid    in   1                record present this cycle
//  trc_pc       in   XLEN             retired pc
//  trc_inst     in   32               retired instruction
//  trc_wb_addr  in   5                writeback register index
//  trc_wb_data  in   XLEN             writeback data
//  exit         in   1                core exit flag
//  trig_en      in   1                enable pc-match stop
//  trig_pc      in   XLEN             pc that ends capture
//  rd_valid     out  1                stream word valid
//  rd_ready     in   1                consumer accepts word
//  rd_data      out  XLEN             stream word
//  rd_last      out  1                final word of stream
//  count        out  $clog2(DEPTH)+1  entries held, saturates at DEPTH
//  overflow     out  1                records were dropped (STOP) or overwritten (WRAP)
//  timeout      out  1                capture ended by MAX_CYCLES
//  state        out  2                0=IDLE 1=CAPTURE 2=DRAIN 3=DONE
// BEHAVIOUR
//  - Reset: state=IDLE; rd_valid=rd_last=0, rd_data=0, count=0; overflow=timeout=0; pointers=0.
//    Buffer contents are not cleared. Reset mid-CAPTURE or mid-DRAIN aborts immediately.
//  - IDLE/DONE, arm=1: next cycle state=CAPTURE.
//    wr_ptr, count, overflow, timeout and the cycle counter clear. arm is ignored in CAPTURE/DRAIN.
//  - CAPTURE, trc_valid=1 with room (count<DEPTH), or mode=WRAP:
//    - write entry[wr_ptr]; wr_ptr<=wr_ptr+1 mod DEPTH.
//    - count<=min(count+1,DEPTH).
//    - WRAP with count==DEPTH: the oldest entry is overwritten, overflow<=1.
//  - CAPTURE, STOP mode, count==DEPTH, trc_valid=1: record dropped, overflow<=1, next state DRAIN.
//  - Stop conditions, evaluated every CAPTURE cycle:
//    - exit=1
//    - trig_en && trc_valid && trc_pc==trig_pc
//    - cycle counter == MAX_CYCLES-1 (MAX_CYCLES>0); this one also sets timeout<=1
//    Next state=DRAIN. A record valid in the stop cycle is written first, subject to the room rules.
//    Several conditions in the same cycle give a single transition; timeout is set only by the counter.
//  - Cycle counter: +1 every CAPTURE cycle, independent of trc_valid.
//  - DRAIN entry: rd_ptr = (count==DEPTH) ? wr_ptr : 0 (oldest entry); word_idx=0.
//    If count==0, go straight to DONE; rd_valid never asserts.
//  - DRAIN: rd_valid=1. rd_data by word_idx: 0=pc, 1=inst, 2={0,wb_addr}, 3=wb_data.
//    - A word transfers on rd_valid&&rd_ready: word_idx++.
//    - After word 3, rd_ptr++ mod DEPTH.
//    - rd_data and rd_last are held stable while rd_valid&&!rd_ready.
//  - rd_last=1 on word 3 of the count-th entry. Its transfer moves to DONE with rd_valid=0 next cycle.
//  - DONE: outputs count/overflow/timeout hold until re-arm or rst.
//  - Stream length is always exactly 4*count words, oldest entry first.
// TESTING (DEPTH=4, MAX_CYCLES=8 unless noted)
//  1. rst=1 for 2 cycles mid-DRAIN -> state=0, rd_valid=0, count=0, overflow=0, timeout=0.
//  2. STOP mode; arm; records pc=0x0,0x4,0x8; exit=1 -> 12 words starting 0x0, rd_last on the 12th, count=3, overflow=0.
//  3. WRAP mode; 6 records pc=0x00..0x14; exit -> drained pcs 0x08,0x0C,0x10,0x14; count=4, overflow=1.
//  4. STOP mode; 5 back-to-back records -> 5th dropped, DRAIN pcs 0x0..0xC, overflow=1, timeout=0.
//  5. trig_en=1, trig_pc=0x8, rd_ready toggling 1/0 -> 3 entries drained; no word lost or duplicated; rd_data stable while stalled.
//  6. trc_valid=0, exit=0 for 8 cycles after arm -> timeout=1, DONE directly, rd_valid never 1; re-arm returns to CAPTURE.

Source files
------------

// File: rtl/trace_capture_if.sv
// Retire-record input bus and drain word stream of the trace capture buffer.
// slave is the buffer's view; master is the core/consumer side.
interface trace_capture_if #(
  parameter int XLEN = 32
);
  logic            trc_valid;
  logic [XLEN-1:0] trc_pc;
  logic [31:0]     trc_inst;
  logic [4:0]      trc_wb_addr;
  logic [XLEN-1:0] trc_wb_data;
  logic            rd_valid;
  logic            rd_ready;
  logic [XLEN-1:0] rd_data;
  logic            rd_last;

  modport master (
    output trc_valid, trc_pc, trc_inst, trc_wb_addr, trc_wb_data, rd_ready,
    input  rd_valid, rd_data, rd_last
  );

  modport slave (
    input  trc_valid, trc_pc, trc_inst, trc_wb_addr, trc_wb_data, rd_ready,
    output rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/trace_capture.sv
// On-chip retire-trace buffer: captures {pc, inst, wb_addr, wb_data} records until
// exit / pc trigger / cycle timeout, then drains them oldest-first as a word stream.
module trace_capture #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 16,
  parameter int MAX_CYCLES = 13312
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     mode,
  trace_capture_if.slave           tif,
  input  logic                     exit,
  input  logic                     trig_en,
  input  logic [XLEN-1:0]          trig_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     timeout,
  output logic [1:0]               state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CYC_ONE  = CW'(1);
  localparam logic [CW-1:0] CYC_LAST = CW'((MAX_CYCLES > 0) ? MAX_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  logic [XLEN-1:0] mem_pc_r  [DEPTH];
  logic [31:0]     mem_inst_r[DEPTH];
  logic [4:0]      mem_wba_r [DEPTH];
  logic [XLEN-1:0] mem_wbd_r [DEPTH];

  state_t          state_r, state_nxt_s;
  logic [AW-1:0]   wr_ptr_r, wr_ptr_nxt_s, rd_ptr_r, rd_ptr_nxt_s, rd_ptr_inc_s;
  logic [AW:0]     count_r, count_nxt_s, ent_r, ent_nxt_s;
  logic [1:0]      word_idx_r, word_idx_nxt_s;
  logic [CW-1:0]   cyc_r, cyc_nxt_s;
  logic            overflow_r, overflow_nxt_s, timeout_r, timeout_nxt_s;
  logic            rd_valid_r, rd_valid_nxt_s, rd_last_r, rd_last_nxt_s;
  logic [XLEN-1:0] rd_data_r, rd_data_nxt_s;
  logic            wr_en_s, full_s, drop_s, trig_hit_s, tmo_s, stop_s;

  function automatic logic [XLEN-1:0] word_sel(
    input logic [XLEN-1:0] pc,
    input logic [31:0]     inst,
    input logic [4:0]      wba,
    input logic [XLEN-1:0] wbd,
    input logic [1:0]      idx
  );
    case (idx)
      2'd0:    word_sel = pc;
      2'd1:    word_sel = XLEN'(inst);
      2'd2:    word_sel = XLEN'(wba);
      default: word_sel = wbd;
    endcase
  endfunction

  assign full_s       = (count_r == CNT_FULL);
  assign drop_s       = tif.trc_valid && full_s && !mode;
  assign trig_hit_s   = trig_en && tif.trc_valid && (tif.trc_pc == trig_pc);
  assign tmo_s        = (MAX_CYCLES != 0) && (cyc_r == CYC_LAST);
  assign stop_s       = exit || trig_hit_s || tmo_s || drop_s;
  assign rd_ptr_inc_s = rd_ptr_r + PTR_ONE;

  // Next-state and next-output logic for the capture/drain FSM.
  always_comb begin
    state_nxt_s    = state_r;
    wr_ptr_nxt_s   = wr_ptr_r;
    rd_ptr_nxt_s   = rd_ptr_r;
    count_nxt_s    = count_r;
    ent_nxt_s      = ent_r;
    word_idx_nxt_s = word_idx_r;
    cyc_nxt_s      = cyc_r;
    overflow_nxt_s = overflow_r;
    timeout_nxt_s  = timeout_r;
    rd_valid_nxt_s = rd_valid_r;
    rd_last_nxt_s  = rd_last_r;
    rd_data_nxt_s  = rd_data_r;
    wr_en_s        = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          state_nxt_s    = ST_CAPTURE;
          wr_ptr_nxt_s   = {AW{1'b0}};
          count_nxt_s    = {(AW + 1){1'b0}};
          overflow_nxt_s = 1'b0;
          timeout_nxt_s  = 1'b0;
          cyc_nxt_s      = {CW{1'b0}};
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_CAPTURE: begin
        cyc_nxt_s = cyc_r + CYC_ONE;
        if (tif.trc_valid && (!full_s || mode)) begin
          wr_en_s        = 1'b1;
          wr_ptr_nxt_s   = wr_ptr_r + PTR_ONE;
          count_nxt_s    = full_s ? count_r : count_r + CNT_ONE;
          overflow_nxt_s = overflow_r | full_s;
        end else if (drop_s) begin
          overflow_nxt_s = 1'b1;
        end else begin
          wr_en_s = 1'b0;
        end
        if (tmo_s) begin
          timeout_nxt_s = 1'b1;
        end else begin
          timeout_nxt_s = timeout_r;
        end
        if (stop_s && (count_nxt_s == {(AW + 1){1'b0}})) begin
          state_nxt_s = ST_DONE;
        end else if (stop_s) begin
          state_nxt_s    = ST_DRAIN;
          rd_ptr_nxt_s   = (count_nxt_s == CNT_FULL) ? wr_ptr_nxt_s : {AW{1'b0}};
          word_idx_nxt_s = 2'd0;
          ent_nxt_s      = {(AW + 1){1'b0}};
          rd_valid_nxt_s = 1'b1;
          rd_last_nxt_s  = 1'b0;
          // The record written in the stop cycle is not in the array yet.
          rd_data_nxt_s  = (wr_en_s && (wr_ptr_r == rd_ptr_nxt_s)) ? tif.trc_pc
                                                                   : mem_pc_r[rd_ptr_nxt_s];
        end else begin
          state_nxt_s = ST_CAPTURE;
        end
      end
      ST_DRAIN: begin
        if (rd_valid_r && tif.rd_ready && rd_last_r) begin
          state_nxt_s    = ST_DONE;
          rd_valid_nxt_s = 1'b0;
          rd_last_nxt_s  = 1'b0;
        end else if (rd_valid_r && tif.rd_ready && (word_idx_r == 2'd3)) begin
          rd_ptr_nxt_s   = rd_ptr_inc_s;
          word_idx_nxt_s = 2'd0;
          ent_nxt_s      = ent_r + CNT_ONE;
          rd_data_nxt_s  = mem_pc_r[rd_ptr_inc_s];
          rd_last_nxt_s  = 1'b0;
        end else if (rd_valid_r && tif.rd_ready) begin
          word_idx_nxt_s = word_idx_r + 2'd1;
          rd_data_nxt_s  = word_sel(mem_pc_r[rd_ptr_r], mem_inst_r[rd_ptr_r],
                                    mem_wba_r[rd_ptr_r], mem_wbd_r[rd_ptr_r],
                                    word_idx_r + 2'd1);
          rd_last_nxt_s  = (word_idx_r == 2'd2) && ((ent_r + CNT_ONE) == count_r);
        end else begin
          rd_data_nxt_s = rd_data_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and control register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW + 1){1'b0}};
      ent_r      <= {(AW + 1){1'b0}};
      word_idx_r <= 2'd0;
      cyc_r      <= {CW{1'b0}};
      overflow_r <= 1'b0;
      timeout_r  <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
      rd_data_r  <= {XLEN{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      count_r    <= count_nxt_s;
      ent_r      <= ent_nxt_s;
      word_idx_r <= word_idx_nxt_s;
      cyc_r      <= cyc_nxt_s;
      overflow_r <= overflow_nxt_s;
      timeout_r  <= timeout_nxt_s;
      rd_valid_r <= rd_valid_nxt_s;
      rd_last_r  <= rd_last_nxt_s;
      rd_data_r  <= rd_data_nxt_s;
    end
  end

  // Record storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s && !rst) begin
      mem_pc_r[wr_ptr_r]   <= tif.trc_pc;
      mem_inst_r[wr_ptr_r] <= tif.trc_inst;
      mem_wba_r[wr_ptr_r]  <= tif.trc_wb_addr;
      mem_wbd_r[wr_ptr_r]  <= tif.trc_wb_data;
    end
  end

  assign tif.rd_valid = rd_valid_r;
  assign tif.rd_data  = rd_data_r;
  assign tif.rd_last  = rd_last_r;
  assign count        = count_r;
  assign overflow     = overflow_r;
  assign timeout      = timeout_r;
  assign state        = state_r;

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture with DEPTH=4, MAX_CYCLES=8.
// Records are derived from pc so every drained word has a known value.
module tb_trace_capture;
  localparam int XLEN       = 32;
  localparam int DEPTH      = 4;
  localparam int MAX_CYCLES = 8;

  logic        clk_s = 1'b0;
  logic        rst_s, arm_s, mode_s, exit_s, trig_en_s;
  logic [31:0] trig_pc_s;
  logic [2:0]  count_s;
  logic        overflow_s, timeout_s;
  logic [1:0]  state_s;
  int          n_tests = 0;
  int          n_fail  = 0;

  trace_capture_if #(.XLEN(XLEN)) tif ();

  trace_capture #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_CYCLES(MAX_CYCLES)) dut (
    .clk     (clk_s),
    .rst     (rst_s),
    .arm     (arm_s),
    .mode    (mode_s),
    .tif     (tif.slave),
    .exit    (exit_s),
    .trig_en (trig_en_s),
    .trig_pc (trig_pc_s),
    .count   (count_s),
    .overflow(overflow_s),
    .timeout (timeout_s),
    .state   (state_s)
  );

  always #5 clk_s = ~clk_s;

  task automatic tick();
    @(posedge clk_s);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] pc, input int idx);
    case (idx)
      0:       exp_word = pc;
      1:       exp_word = 32'hA000_0000 + pc;
      2:       exp_word = {27'd0, pc[6:2]};
      default: exp_word = 32'hD000_0000 + pc;
    endcase
  endfunction

  task automatic rec_set(input logic [31:0] pc);
    tif.trc_valid   = 1'b1;
    tif.trc_pc      = pc;
    tif.trc_inst    = 32'hA000_0000 + pc;
    tif.trc_wb_addr = pc[6:2];
    tif.trc_wb_data = 32'hD000_0000 + pc;
  endtask

  task automatic arm_cap(input logic m);
    arm_s  = 1'b1;
    mode_s = m;
    tick();
    arm_s = 1'b0;
    check("arm_state", {30'd0, state_s}, 32'd1);
  endtask

  // Drain n_ent consecutive entries starting at pc0; optionally toggle ready.
  task automatic drain(input int n_ent, input logic [31:0] pc0, input bit toggle);
    int          w       = 0;
    int          cyc     = 0;
    bit          stalled = 1'b0;
    logic [31:0] held    = 32'd0;
    while (w < 4 * n_ent && cyc < 200) begin
      tif.rd_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
      if (tif.rd_valid) begin
        if (stalled) check("stall_hold", tif.rd_data, held);
        if (tif.rd_ready) begin
          check("word", tif.rd_data, exp_word(pc0 + 32'(4 * (w / 4)), w % 4));
          check("last", {31'd0, tif.rd_last}, {31'd0, (w == 4 * n_ent - 1)});
          w++;
          stalled = 1'b0;
        end else begin
          held    = tif.rd_data;
          stalled = 1'b1;
        end
      end
      tick();
      cyc++;
    end
    tif.rd_ready = 1'b0;
    check("drain_words", w, 4 * n_ent);
    check("done_state", {30'd0, state_s}, 32'd3);
    check("done_valid", {31'd0, tif.rd_valid}, 32'd0);
  endtask

  initial begin
    rst_s = 1'b1; arm_s = 1'b0; mode_s = 1'b0; exit_s = 1'b0;
    trig_en_s = 1'b0; trig_pc_s = 32'd0;
    tif.trc_valid = 1'b0; tif.trc_pc = 32'd0; tif.trc_inst = 32'd0;
    tif.trc_wb_addr = 5'd0; tif.trc_wb_data = 32'd0; tif.rd_ready = 1'b0;
    tick(); tick();
    rst_s = 1'b0;
    check("rst_state", {30'd0, state_s}, 32'd0);
    check("rst_valid", {31'd0, tif.rd_valid}, 32'd0);
    check("rst_data",  tif.rd_data, 32'd0);
    check("rst_count", {29'd0, count_s}, 32'd0);

    // STOP: three records then exit
    arm_cap(1'b0);
    for (int i = 0; i < 3; i++) begin rec_set(32'(4 * i)); tick(); end
    tif.trc_valid = 1'b0; exit_s = 1'b1; tick(); exit_s = 1'b0;
    check("t2_state", {30'd0, state_s}, 32'd2);
    drain(3, 32'h0, 1'b0);
    check("t2_count", {29'd0, count_s}, 32'd3);
    check("t2_ovf", {31'd0, overflow_s}, 32'd0);

    // WRAP: six records keep the last four
    arm_cap(1'b1);
    for (int i = 0; i < 6; i++) begin rec_set(32'(4 * i)); tick(); end
    tif.trc_valid = 1'b0; exit_s = 1'b1; tick(); exit_s = 1'b0;
    drain(4, 32'h8, 1'b0);
    check("t3_count", {29'd0, count_s}, 32'd4);
    check("t3_ovf", {31'd0, overflow_s}, 32'd1);

    // STOP: fifth back-to-back record is dropped and ends capture
    arm_cap(1'b0);
    for (int i = 0; i < 5; i++) begin rec_set(32'(4 * i)); tick(); end
    tif.trc_valid = 1'b0;
    check("t4_state", {30'd0, state_s}, 32'd2);
    drain(4, 32'h0, 1'b0);
    check("t4_ovf", {31'd0, overflow_s}, 32'd1);
    check("t4_tmo", {31'd0, timeout_s}, 32'd0);

    // PC trigger with a stalling consumer
    trig_en_s = 1'b1; trig_pc_s = 32'h8;
    arm_cap(1'b0);
    for (int i = 0; i < 3; i++) begin rec_set(32'(4 * i)); tick(); end
    tif.trc_valid = 1'b0; trig_en_s = 1'b0;
    check("t5_state", {30'd0, state_s}, 32'd2);
    drain(3, 32'h0, 1'b1);
    check("t5_count", {29'd0, count_s}, 32'd3);

    // Timeout with no records, then re-arm
    arm_cap(1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("t6_novalid", {31'd0, tif.rd_valid}, 32'd0);
    end
    check("t6_pre", {30'd0, state_s}, 32'd1);
    tick();
    check("t6_state", {30'd0, state_s}, 32'd3);
    check("t6_tmo", {31'd0, timeout_s}, 32'd1);
    check("t6_count", {29'd0, count_s}, 32'd0);
    check("t6_valid", {31'd0, tif.rd_valid}, 32'd0);
    tick();
    check("t6_valid2", {31'd0, tif.rd_valid}, 32'd0);
    arm_cap(1'b0);
    check("t6_rearm_tmo", {31'd0, timeout_s}, 32'd0);
    exit_s = 1'b1; tick(); exit_s = 1'b0;
    check("t6_empty_done", {30'd0, state_s}, 32'd3);

    // Reset in the middle of a drain
    arm_cap(1'b1);
    for (int i = 0; i < 5; i++) begin rec_set(32'(4 * i)); tick(); end
    tif.trc_valid = 1'b0; exit_s = 1'b1; tick(); exit_s = 1'b0;
    tif.rd_ready = 1'b1;
    check("t1_w0", tif.rd_data, 32'h4);
    tick(); tick();
    tif.rd_ready = 1'b0;
    check("t1_mid", {30'd0, state_s}, 32'd2);
    rst_s = 1'b1; tick(); tick(); rst_s = 1'b0;
    check("t1_state", {30'd0, state_s}, 32'd0);
    check("t1_valid", {31'd0, tif.rd_valid}, 32'd0);
    check("t1_count", {29'd0, count_s}, 32'd0);
    check("t1_ovf", {31'd0, overflow_s}, 32'd0);
    check("t1_tmo", {31'd0, timeout_s}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
